// File: rtl/udp_line_rx_pkg.sv
// Shared encodings and constants for the UDP line receiver.
// Holds the FSM state type, protocol header lengths and fixed field values.
// Also provides a byte-extraction helper used by the header matcher.
package udp_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    ETH_HDR,
    IP_HDR,
    UDP_HDR,
    LINE_NUM,
    PAYLOAD,
    DRAIN
  } state_t;

  localparam int CNT_W       = 16;
  localparam int ETH_HDR_LEN = 14;
  localparam int IP_HDR_LEN  = 20;
  localparam int UDP_HDR_LEN = 8;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;

  // Byte k of v, counting from the least significant byte.
  function automatic logic [7:0] byte_at(input logic [47:0] v, input int k);
    logic [47:0] s;
    s = v >> (8 * k);
    return s[7:0];
  endfunction

endpackage

// File: rtl/udp_line_rx_if.sv
// Line/pixel delivery bus from the UDP line receiver to the frame buffer.
// master: receiver drives line_num/line_start/pix_*/line_done/pkt_drop/pkt_cnt.
// slave: consumer samples them; no backpressure, the consumer must keep up.
interface udp_line_rx_if #(
  parameter int ADDR_W = 8
);
  logic [15:0]       line_num;
  logic              line_start;
  logic [7:0]        pix_data;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_valid;
  logic              line_done;
  logic              pkt_drop;
  logic [15:0]       pkt_cnt;

  modport master (
    output line_num, line_start, pix_data, pix_addr, pix_valid,
           line_done, pkt_drop, pkt_cnt
  );

  modport slave (
    input line_num, line_start, pix_data, pix_addr, pix_valid,
          line_done, pkt_drop, pkt_cnt
  );
endinterface

// File: rtl/udp_line_rx_hdr_match.sv
// Combinational header field checker for the byte in flight.
// Ports: state/cnt/rxd select the field; mac_*_run carry the running MAC verdicts.
// Outputs field_bad for the current byte plus per-byte MAC hits; zero latency.
module udp_hdr_match
  import udp_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC      = 48'h00_00_00_00_00_00,
  parameter logic [31:0] LOCAL_IP       = 32'hc0_a8_00_03,
  parameter logic [15:0] LOCAL_UDP_PORT = 16'd6102,
  parameter int          DATA_LENGTH    = 162
) (
  input  state_t           state,
  input  logic [CNT_W-1:0] cnt,
  input  logic [7:0]       rxd,
  input  logic             mac_lcl_run,
  input  logic             mac_bc_run,
  output logic             mac_lcl_hit,
  output logic             mac_bc_hit,
  output logic             field_bad
);

  localparam logic [15:0] UDP_LEN = 16'(DATA_LENGTH + UDP_HDR_LEN);

  always_comb begin
    mac_lcl_hit = 1'b0;
    mac_bc_hit  = 1'b0;
    field_bad   = 1'b0;
    case (state)
      ETH_HDR: begin
        if (cnt < 6) begin
          // Either all six bytes match the local MAC or all six are 0xFF;
          // the run flags stop a mix of the two from passing.
          mac_lcl_hit = (rxd == byte_at(LOCAL_MAC, 5 - int'(cnt)));
          mac_bc_hit  = (rxd == 8'hFF);
          field_bad   = !((mac_lcl_hit && mac_lcl_run) || (mac_bc_hit && mac_bc_run));
        end else if (cnt == 12) begin
          field_bad = (rxd != ETHERTYPE_IPV4[15:8]);
        end else if (cnt == 13) begin
          field_bad = (rxd != ETHERTYPE_IPV4[7:0]);
        end
      end
      IP_HDR: begin
        if (cnt == 0) begin
          field_bad = (rxd != IP_VER_IHL);
        end else if (cnt == 9) begin
          field_bad = (rxd != IP_PROTO_UDP);
        end else if (cnt >= 16 && cnt <= 19) begin
          field_bad = (rxd != byte_at({16'h0, LOCAL_IP}, 19 - int'(cnt)));
        end
      end
      UDP_HDR: begin
        if (cnt == 2 || cnt == 3) begin
          field_bad = (rxd != byte_at({32'h0, LOCAL_UDP_PORT}, 3 - int'(cnt)));
        end else if (cnt == 4 || cnt == 5) begin
          field_bad = (rxd != byte_at({32'h0, UDP_LEN}, 5 - int'(cnt)));
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/udp_line_rx.sv
// GMII Ethernet/IPv4/UDP receiver delivering one Sobel image line per packet.
// Ports: clk/rst_n, gmii_rxd/gmii_rx_dv/gmii_rx_er in; lb (master) carries line/pixel outputs.
// Latency: every output is registered, one cycle after the causing byte; no backpressure.
module udp_line_rx
  import udp_rx_pkg::*;
#(
  parameter int          IMAGE_WIDTH    = 1280,
  parameter logic [47:0] LOCAL_MAC      = 48'h00_00_00_00_00_00,
  parameter logic [31:0] LOCAL_IP       = 32'hc0_a8_00_03,
  parameter logic [15:0] LOCAL_UDP_PORT = 16'd6102,
  parameter int          DATA_LENGTH    = IMAGE_WIDTH / 8 + 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   gmii_rxd,
  input  logic         gmii_rx_dv,
  input  logic         gmii_rx_er,
  udp_line_rx_if.master lb
);

  localparam int LINE_BYTES = IMAGE_WIDTH / 8;
  localparam int ADDR_W     = $clog2(LINE_BYTES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       line_hi;
  logic             rx_dv_q;
  logic             mac_lcl_run;
  logic             mac_bc_run;
  logic             mac_lcl_hit;
  logic             mac_bc_hit;
  logic             field_bad;
  logic             in_frame;

  udp_hdr_match #(
    .LOCAL_MAC      (LOCAL_MAC),
    .LOCAL_IP       (LOCAL_IP),
    .LOCAL_UDP_PORT (LOCAL_UDP_PORT),
    .DATA_LENGTH    (DATA_LENGTH)
  ) u_match (
    .state       (state),
    .cnt         (cnt),
    .rxd         (gmii_rxd),
    .mac_lcl_run (mac_lcl_run),
    .mac_bc_run  (mac_bc_run),
    .mac_lcl_hit (mac_lcl_hit),
    .mac_bc_hit  (mac_bc_hit),
    .field_bad   (field_bad)
  );

  // States where losing rx_dv means the frame was cut short.
  assign in_frame = (state == ETH_HDR) || (state == IP_HDR) || (state == UDP_HDR) ||
                    (state == LINE_NUM) || (state == PAYLOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      line_hi       <= '0;
      // Assume the line is busy until rx_dv is seen low, so a reset released
      // mid-frame never parses the tail as a new frame.
      rx_dv_q       <= 1'b1;
      mac_lcl_run   <= 1'b0;
      mac_bc_run    <= 1'b0;
      lb.line_num   <= '0;
      lb.line_start <= 1'b0;
      lb.pix_data   <= '0;
      lb.pix_addr   <= '0;
      lb.pix_valid  <= 1'b0;
      lb.line_done  <= 1'b0;
      lb.pkt_drop   <= 1'b0;
      lb.pkt_cnt    <= '0;
    end else begin
      rx_dv_q       <= gmii_rx_dv;
      lb.line_start <= 1'b0;
      lb.pix_valid  <= 1'b0;
      lb.line_done  <= 1'b0;
      lb.pkt_drop   <= 1'b0;
      if (gmii_rx_dv) begin
        cnt <= cnt + 1'b1;
      end

      if (in_frame && !gmii_rx_dv) begin
        lb.pkt_drop <= 1'b1;
        state       <= IDLE;
        cnt         <= '0;
      end else if (state != IDLE && state != DRAIN && gmii_rx_dv && gmii_rx_er) begin
        lb.pkt_drop <= 1'b1;
        state       <= DRAIN;
        cnt         <= '0;
      end else if (in_frame && field_bad) begin
        lb.pkt_drop <= 1'b1;
        state       <= DRAIN;
        cnt         <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (gmii_rx_dv) begin
              cnt   <= '0;
              state <= (!rx_dv_q && gmii_rxd == PREAMBLE_BYTE) ? PREAMBLE : DRAIN;
            end
          end
          PREAMBLE: begin
            if (!gmii_rx_dv) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (gmii_rxd == SFD_BYTE) begin
              state       <= ETH_HDR;
              cnt         <= '0;
              mac_lcl_run <= 1'b1;
              mac_bc_run  <= 1'b1;
            end else if (gmii_rxd != PREAMBLE_BYTE) begin
              state <= DRAIN;
              cnt   <= '0;
            end
          end
          ETH_HDR: begin
            if (cnt < 6) begin
              mac_lcl_run <= mac_lcl_run & mac_lcl_hit;
              mac_bc_run  <= mac_bc_run & mac_bc_hit;
            end
            if (cnt == CNT_W'(ETH_HDR_LEN - 1)) begin
              state <= IP_HDR;
              cnt   <= '0;
            end
          end
          IP_HDR: begin
            if (cnt == CNT_W'(IP_HDR_LEN - 1)) begin
              state <= UDP_HDR;
              cnt   <= '0;
            end
          end
          UDP_HDR: begin
            if (cnt == CNT_W'(UDP_HDR_LEN - 1)) begin
              state <= LINE_NUM;
              cnt   <= '0;
            end
          end
          LINE_NUM: begin
            if (cnt == 0) begin
              line_hi <= gmii_rxd;
            end else begin
              lb.line_num   <= {line_hi, gmii_rxd};
              lb.line_start <= 1'b1;
              state         <= PAYLOAD;
              cnt           <= '0;
            end
          end
          PAYLOAD: begin
            lb.pix_valid <= 1'b1;
            lb.pix_data  <= gmii_rxd;
            lb.pix_addr  <= cnt[ADDR_W-1:0];
            if (cnt == CNT_W'(LINE_BYTES - 1)) begin
              lb.line_done <= 1'b1;
              lb.pkt_cnt   <= lb.pkt_cnt + 16'd1;
              state        <= DRAIN;
              cnt          <= '0;
            end
          end
          DRAIN: begin
            if (!gmii_rx_dv) begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
